// File: rtl/program_sequencer_if.sv
// program_sequencer_if: control inputs and status outputs of the program sequencer.
// The master drives op/flags and the slave (the sequencer) reports pc/sp/halted/stack pulses.
interface program_sequencer_if #(
    parameter int ADDR_W      = 4,
    parameter int STACK_DEPTH = 4
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    logic              en;
    logic [2:0]        op;
    logic [ADDR_W-1:0] target;
    logic              zero_flag;
    logic              carry_flag;
    logic              resume;
    logic [ADDR_W-1:0] pc;
    logic [SP_W-1:0]   sp;
    logic              halted;
    logic              stack_ovf;
    logic              stack_unf;
    modport master (
        output en, op, target, zero_flag, carry_flag, resume,
        input  pc, sp, halted, stack_ovf, stack_unf
    );
    modport slave (
        input  en, op, target, zero_flag, carry_flag, resume,
        output pc, sp, halted, stack_ovf, stack_unf
    );
endinterface

// File: rtl/program_sequencer.sv
// program_sequencer: program counter with jumps, halt/resume and an optional return stack.
// Define SEQ_STACK_EN to build the call/return stack; otherwise CALL acts as JMP and RET as NEXT.
module program_sequencer #(
    parameter int ADDR_W      = 4,
    parameter int STACK_DEPTH = 4
) (
    input logic                clk,
    input logic                rst_n,
    program_sequencer_if.slave bus
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam logic [2:0] OP_NEXT = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_JZ   = 3'b010;
    localparam logic [2:0] OP_JC   = 3'b011;
    localparam logic [2:0] OP_CALL = 3'b100;
    localparam logic [2:0] OP_RET  = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
    logic              halted_q, halted_d;
    assign pc_inc = pc_q + 1'b1;
`ifdef SEQ_STACK_EN
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              ovf_q, ovf_d, unf_q, unf_d, push, full, empty;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0] top;
    assign full  = sp_q == SP_W'(STACK_DEPTH);
    assign empty = sp_q == '0;
    // Decoded read of entry sp-1 avoids indexing the array with the wider sp value.
    always_comb begin
        top = '0;
        for (int i = 0; i < STACK_DEPTH; i++)
            if (sp_q == SP_W'(i + 1)) top = stack_q[i];
    end
`endif
    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q;
`ifdef SEQ_STACK_EN
        sp_d  = sp_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        push  = 1'b0;
`endif
        if (bus.en && halted_q) begin
            halted_d = !bus.resume;
            pc_d     = bus.resume ? pc_inc : pc_q;
        end else if (bus.en) begin
            case (bus.op)
                OP_NEXT: pc_d = pc_inc;
                OP_JMP:  pc_d = bus.target;
                OP_JZ:   pc_d = bus.zero_flag ? bus.target : pc_inc;
                OP_JC:   pc_d = bus.carry_flag ? bus.target : pc_inc;
`ifdef SEQ_STACK_EN
                OP_CALL: begin
                    push  = !full;
                    sp_d  = full ? sp_q : sp_q + 1'b1;
                    pc_d  = full ? pc_inc : bus.target;
                    ovf_d = full;
                end
                OP_RET: begin
                    sp_d  = empty ? sp_q : sp_q - 1'b1;
                    pc_d  = empty ? pc_inc : top;
                    unf_d = empty;
                end
`else
                OP_CALL: pc_d = bus.target;
                OP_RET:  pc_d = pc_inc;
`endif
                OP_HALT: halted_d = 1'b1;
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end
    assign bus.pc     = pc_q;
    assign bus.halted = halted_q;
`ifdef SEQ_STACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end
    // Return addresses are deliberately not reset; entries above sp are never read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++)
            if (push && sp_q == SP_W'(i)) stack_q[i] <= pc_inc;
    end
    assign bus.sp        = sp_q;
    assign bus.stack_ovf = ovf_q;
    assign bus.stack_unf = unf_q;
`else
    assign bus.sp        = SP_W'(0);
    assign bus.stack_ovf = 1'b0;
    assign bus.stack_unf = 1'b0;
`endif
endmodule
